dram_req_arbiter: RTL and testbench

DRAM_REQ_ARBITER -- requirements
Module: dram_req_arbiter

---
 rtl/dram_req_arbiter.sv | 160 ++++++++++++++++
 tb/tb_dram_req_arbiter.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dram_req_arbiter.sv
// Round-robin arbiter merging scratchpad backend beats into one DRAM request queue.
// Multi-beat bursts hold the grant; per-requester credit counters limit outstanding bursts.
module dram_req_arbiter #(
  parameter int NUM_REQ         = 2,
  parameter int DRAM_ADDR_WIDTH = 32,
  parameter int DRAM_ID_WIDTH   = 8,
  parameter int COL_IDX_WIDTH   = 5,
  parameter int DATA_WIDTH      = 256,
  parameter int MAX_OUTSTANDING = 4,
  localparam int SRC_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int TAG_W = SRC_W + DRAM_ID_WIDTH
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_REQ-1:0]               req_valid,
  output logic [NUM_REQ-1:0]               req_ready,
  input  logic [NUM_REQ-1:0]               req_write,
  input  logic [NUM_REQ-1:0]               req_last,
  input  logic [NUM_REQ*DRAM_ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DRAM_ID_WIDTH-1:0] req_id,
  input  logic [NUM_REQ*COL_IDX_WIDTH-1:0] req_nbytes,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_wdata,
  output logic                             dram_req_valid,
  output logic                             dram_req_write,
  output logic                             dram_req_last,
  output logic [DRAM_ADDR_WIDTH-1:0]       dram_req_addr,
  output logic [TAG_W-1:0]                 dram_req_id,
  output logic [COL_IDX_WIDTH-1:0]         dram_req_nbytes,
  output logic [DATA_WIDTH-1:0]            dram_req_wdata,
  input  logic                             dram_be_stall,
  input  logic                             dram_rsp_valid,
  input  logic [TAG_W-1:0]                 dram_rsp_id,
  output logic [NUM_REQ-1:0]               rsp_valid,
  output logic [DRAM_ID_WIDTH-1:0]         rsp_id,
  output logic                             err
);

  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

  typedef enum logic {
    IDLE,
    LOCKED
  } state_t;

  state_t            state;
  logic [SRC_W-1:0]  owner;
  logic [SRC_W-1:0]  rr_ptr;
  logic [CNT_W-1:0]  cnt [NUM_REQ];

  logic              load_ok;
  logic [NUM_REQ-1:0] elig;
  logic              gnt_vld;
  logic [SRC_W-1:0]  gnt_idx;
  logic [SRC_W-1:0]  nxt_ptr;
  int                sel;
  int                p;
  logic              accept;
  logic              acc_last;
  logic [SRC_W-1:0]  tag;
  logic              tag_ok;
  logic [NUM_REQ-1:0] cnt_zero;

  assign load_ok = !dram_req_valid || !dram_be_stall;
  assign sel     = int'(gnt_idx);

  always_comb begin
    elig     = '0;
    cnt_zero = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      elig[i]     = req_valid[i] && (cnt[i] < CNT_W'(MAX_OUTSTANDING));
      cnt_zero[i] = (cnt[i] == '0);
    end
  end

  // A locked burst keeps the owner; otherwise scan from rr_ptr with wrap.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    p       = 0;
    if (state == LOCKED) begin
      gnt_vld = 1'b1;
      gnt_idx = owner;
    end else begin
      for (int k = 0; k < NUM_REQ; k++) begin
        p = int'(rr_ptr) + k;
        if (p >= NUM_REQ) p = p - NUM_REQ;
        if (!gnt_vld && elig[p]) begin
          gnt_vld = 1'b1;
          gnt_idx = SRC_W'(p);
        end
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (gnt_vld && load_ok) req_ready[sel] = 1'b1;
  end

  assign accept   = gnt_vld && load_ok && req_valid[sel];
  assign acc_last = accept && req_last[sel];
  assign nxt_ptr  = (sel == NUM_REQ - 1) ? '0 : gnt_idx + 1'b1;

  assign tag    = dram_rsp_id[TAG_W-1 -: SRC_W];
  assign tag_ok = int'(tag) < NUM_REQ;
  assign rsp_id = dram_rsp_id[DRAM_ID_WIDTH-1:0];

  always_comb begin
    rsp_valid = '0;
    if (dram_rsp_valid && tag_ok) rsp_valid[tag] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      owner           <= '0;
      rr_ptr          <= '0;
      err             <= 1'b0;
      dram_req_valid  <= 1'b0;
      dram_req_write  <= 1'b0;
      dram_req_last   <= 1'b0;
      dram_req_addr   <= '0;
      dram_req_id     <= '0;
      dram_req_nbytes <= '0;
      dram_req_wdata  <= '0;
      for (int i = 0; i < NUM_REQ; i++) cnt[i] <= '0;
    end else begin
      if (load_ok) begin
        dram_req_valid <= accept;
        if (accept) begin
          dram_req_write  <= req_write[sel];
          dram_req_last   <= req_last[sel];
          dram_req_addr   <= req_addr[sel*DRAM_ADDR_WIDTH +: DRAM_ADDR_WIDTH];
          dram_req_id     <= {gnt_idx, req_id[sel*DRAM_ID_WIDTH +: DRAM_ID_WIDTH]};
          dram_req_nbytes <= req_nbytes[sel*COL_IDX_WIDTH +: COL_IDX_WIDTH];
          dram_req_wdata  <= req_wdata[sel*DATA_WIDTH +: DATA_WIDTH];
        end
      end
      if (accept) begin
        if (req_last[sel]) begin
          state  <= IDLE;
          rr_ptr <= nxt_ptr;
        end else if (state == IDLE) begin
          state <= LOCKED;
          owner <= gnt_idx;
        end
      end
      // Issue and completion in one cycle cancel; never underflow.
      for (int i = 0; i < NUM_REQ; i++) begin
        if (acc_last && sel == i && !rsp_valid[i])
          cnt[i] <= cnt[i] + 1'b1;
        else if (rsp_valid[i] && !(acc_last && sel == i) && !cnt_zero[i])
          cnt[i] <= cnt[i] - 1'b1;
      end
      if (dram_rsp_valid && (!tag_ok || |(rsp_valid & cnt_zero)))
        err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_dram_req_arbiter.sv
// Directed bench for dram_req_arbiter: round robin, bursts,
// stall hold, credit limit, error flag and mid-burst reset.
module tb_dram_req_arbiter;

  localparam int N  = 2;
  localparam int AW = 32;
  localparam int IW = 8;
  localparam int CW = 5;
  localparam int DW = 256;
  localparam int TW = 9;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    req_valid, req_ready, req_write, req_last, rsp_valid;
  logic [N*AW-1:0] req_addr;
  logic [N*IW-1:0] req_id;
  logic [N*CW-1:0] req_nbytes;
  logic [N*DW-1:0] req_wdata;
  logic            dram_req_valid, dram_req_write, dram_req_last;
  logic [AW-1:0]   dram_req_addr;
  logic [TW-1:0]   dram_req_id;
  logic [CW-1:0]   dram_req_nbytes;
  logic [DW-1:0]   dram_req_wdata;
  logic            dram_be_stall, dram_rsp_valid, err;
  logic [TW-1:0]   dram_rsp_id;
  logic [IW-1:0]   rsp_id;

  int checks = 0;
  int errors = 0;

  dram_req_arbiter dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_last(req_last),
    .req_addr(req_addr), .req_id(req_id),
    .req_nbytes(req_nbytes), .req_wdata(req_wdata),
    .dram_req_valid(dram_req_valid), .dram_req_write(dram_req_write),
    .dram_req_last(dram_req_last), .dram_req_addr(dram_req_addr),
    .dram_req_id(dram_req_id), .dram_req_nbytes(dram_req_nbytes),
    .dram_req_wdata(dram_req_wdata), .dram_be_stall(dram_be_stall),
    .dram_rsp_valid(dram_rsp_valid), .dram_rsp_id(dram_rsp_id),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .err(err)
  );

  always #5 clk = ~clk;

  task automatic clear_inputs();
    req_valid      = '0;
    req_write      = '0;
    req_last       = '0;
    req_addr       = '0;
    req_id         = '0;
    req_nbytes     = '0;
    req_wdata      = '0;
    dram_be_stall  = 1'b0;
    dram_rsp_valid = 1'b0;
    dram_rsp_id    = '0;
  endtask

  task automatic set_req(input int i, input logic v, input logic l,
                         input logic [AW-1:0] a, input logic [IW-1:0] id);
    req_valid[i]            = v;
    req_write[i]            = 1'b1;
    req_last[i]             = l;
    req_addr[i*AW +: AW]    = a;
    req_id[i*IW +: IW]      = id;
    req_nbytes[i*CW +: CW]  = a[4:0];
    req_wdata[i*DW +: DW]   = {8{a}};
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    clear_inputs();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++;
    if ({dram_req_valid, dram_req_write, dram_req_last} !== 3'b000) begin
      errors++;
      $display("FAIL reset_ctl got %b exp 000",
               {dram_req_valid, dram_req_write, dram_req_last});
    end
    checks++;
    if (dram_req_addr !== '0 || dram_req_id !== '0 || dram_req_nbytes !== '0) begin
      errors++;
      $display("FAIL reset_fields addr %h id %h nb %h exp 0",
               dram_req_addr, dram_req_id, dram_req_nbytes);
    end
    checks++;
    if (err !== 1'b0 || req_ready !== 2'b00 || rsp_valid !== 2'b00) begin
      errors++;
      $display("FAIL reset_misc err %b ready %b rsp %b exp 0 00 00",
               err, req_ready, rsp_valid);
    end
  endtask

  task automatic test_alternate();
    logic [TW-1:0] exp_id;
    logic [N-1:0]  exp_rdy;
    do_reset();
    set_req(0, 1'b1, 1'b1, 32'h100, 8'h10);
    set_req(1, 1'b1, 1'b1, 32'h200, 8'h20);
    for (int k = 0; k < 4; k++) begin
      exp_rdy = (k % 2 == 1) ? 2'b10 : 2'b01;
      exp_id  = (k % 2 == 1) ? 9'h120 : 9'h010;
      #1;
      checks++;
      if (req_ready !== exp_rdy) begin
        errors++;
        $display("FAIL alt_ready k=%0d got %b exp %b", k, req_ready, exp_rdy);
      end
      @(negedge clk);
      checks++;
      if (dram_req_valid !== 1'b1 || dram_req_id !== exp_id) begin
        errors++;
        $display("FAIL alt_out k=%0d valid %b id %h exp 1 %h",
                 k, dram_req_valid, dram_req_id, exp_id);
      end
    end
  endtask

  task automatic test_burst();
    logic [AW-1:0] exp_a;
    do_reset();
    set_req(1, 1'b1, 1'b1, 32'h900, 8'hAB);
    for (int k = 0; k < 4; k++) begin
      set_req(0, 1'b1, k == 3, 32'h1000 + 32'(k * 32), 8'h5);
      #1;
      checks++;
      if (req_ready !== 2'b01) begin
        errors++;
        $display("FAIL burst_ready k=%0d got %b exp 01", k, req_ready);
      end
      @(negedge clk);
      exp_a = 32'h1000 + 32'(k * 32);
      checks++;
      if (dram_req_addr !== exp_a || dram_req_id !== 9'h005 ||
          dram_req_last !== (k == 3) || dram_req_wdata !== {8{exp_a}}) begin
        errors++;
        $display("FAIL burst_out k=%0d addr %h id %h last %b exp %h 005 %b",
                 k, dram_req_addr, dram_req_id, dram_req_last, exp_a, k == 3);
      end
    end
    #1;
    checks++;
    if (req_ready !== 2'b10) begin
      errors++;
      $display("FAIL burst_handoff got %b exp 10", req_ready);
    end
    @(negedge clk);
    checks++;
    if (dram_req_id !== 9'h1AB || dram_req_addr !== 32'h900) begin
      errors++;
      $display("FAIL burst_src1 id %h addr %h exp 1ab 900", dram_req_id, dram_req_addr);
    end
    clear_inputs();
  endtask

  task automatic test_stall();
    do_reset();
    set_req(0, 1'b1, 1'b1, 32'hAAA0, 8'h11);
    @(negedge clk);
    set_req(0, 1'b1, 1'b1, 32'hBBB0, 8'h22);
    dram_be_stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++;
      if (dram_req_valid !== 1'b1 || dram_req_addr !== 32'hAAA0 ||
          dram_req_id !== 9'h011 || req_ready !== 2'b00) begin
        errors++;
        $display("FAIL stall_hold k=%0d valid %b addr %h id %h ready %b exp 1 aaa0 011 00",
                 k, dram_req_valid, dram_req_addr, dram_req_id, req_ready);
      end
      @(negedge clk);
    end
    dram_be_stall = 1'b0;
    #1;
    checks++;
    if (req_ready !== 2'b01) begin
      errors++;
      $display("FAIL stall_release got %b exp 01", req_ready);
    end
    @(negedge clk);
    checks++;
    if (dram_req_valid !== 1'b1 || dram_req_addr !== 32'hBBB0) begin
      errors++;
      $display("FAIL stall_next valid %b addr %h exp 1 bbb0", dram_req_valid, dram_req_addr);
    end
    req_valid = '0;
    @(negedge clk);
    checks++;
    if (dram_req_valid !== 1'b0) begin
      errors++;
      $display("FAIL stall_drain got %b exp 0", dram_req_valid);
    end
  endtask

  task automatic test_outstanding();
    do_reset();
    set_req(0, 1'b1, 1'b1, 32'h40, 8'h01);
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++;
      if (req_ready !== 2'b01) begin
        errors++;
        $display("FAIL out_issue k=%0d got %b exp 01", k, req_ready);
      end
      @(negedge clk);
    end
    #1;
    checks++;
    if (req_ready !== 2'b00) begin
      errors++;
      $display("FAIL out_block got %b exp 00", req_ready);
    end
    set_req(1, 1'b1, 1'b1, 32'h80, 8'h02);
    #1;
    checks++;
    if (req_ready !== 2'b10) begin
      errors++;
      $display("FAIL out_other got %b exp 10", req_ready);
    end
    @(negedge clk);
    checks++;
    if (dram_req_id !== 9'h102) begin
      errors++;
      $display("FAIL out_served got %h exp 102", dram_req_id);
    end
    req_valid[1]   = 1'b0;
    dram_rsp_valid = 1'b1;
    dram_rsp_id    = 9'h055;
    #1;
    checks++;
    if (rsp_valid !== 2'b01 || rsp_id !== 8'h55) begin
      errors++;
      $display("FAIL out_route rsp %b id %h exp 01 55", rsp_valid, rsp_id);
    end
    @(negedge clk);
    dram_rsp_valid = 1'b0;
    #1;
    checks++;
    if (req_ready !== 2'b01 || err !== 1'b0) begin
      errors++;
      $display("FAIL out_reopen ready %b err %b exp 01 0", req_ready, err);
    end
    clear_inputs();
  endtask

  task automatic test_err_cancel();
    do_reset();
    set_req(0, 1'b1, 1'b1, 32'h60, 8'h03);
    @(negedge clk);
    dram_rsp_valid = 1'b1;
    dram_rsp_id    = 9'h003;
    @(negedge clk);
    dram_rsp_valid = 1'b0;
    #1;
    checks++;
    if (err !== 1'b0 || req_ready !== 2'b01) begin
      errors++;
      $display("FAIL cancel_mid err %b ready %b exp 0 01", err, req_ready);
    end
    @(negedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (req_ready !== 2'b01) begin
      errors++;
      $display("FAIL cancel_three got %b exp 01", req_ready);
    end
    @(negedge clk);
    #1;
    checks++;
    if (req_ready !== 2'b00) begin
      errors++;
      $display("FAIL cancel_full got %b exp 00", req_ready);
    end
    req_valid      = '0;
    dram_rsp_valid = 1'b1;
    dram_rsp_id    = 9'h133;
    #1;
    checks++;
    if (rsp_valid !== 2'b10 || rsp_id !== 8'h33) begin
      errors++;
      $display("FAIL err_route rsp %b id %h exp 10 33", rsp_valid, rsp_id);
    end
    @(negedge clk);
    dram_rsp_valid = 1'b0;
    checks++;
    if (err !== 1'b1) begin
      errors++;
      $display("FAIL err_set got %b exp 1", err);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (err !== 1'b1) begin
      errors++;
      $display("FAIL err_sticky got %b exp 1", err);
    end
    do_reset();
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL err_clear got %b exp 0", err);
    end
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    set_req(0, 1'b1, 1'b1, 32'h10, 8'h07);
    @(negedge clk);
    req_valid[0] = 1'b0;
    set_req(1, 1'b1, 1'b0, 32'h2000, 8'h08);
    #1;
    checks++;
    if (req_ready !== 2'b10) begin
      errors++;
      $display("FAIL mid_start got %b exp 10", req_ready);
    end
    @(negedge clk);
    set_req(1, 1'b1, 1'b0, 32'h2020, 8'h08);
    @(negedge clk);
    set_req(1, 1'b1, 1'b0, 32'h2040, 8'h08);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    set_req(0, 1'b1, 1'b1, 32'h30, 8'h09);
    #1;
    checks++;
    if (dram_req_valid !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL mid_flush valid %b err %b exp 0 0", dram_req_valid, err);
    end
    checks++;
    if (req_ready !== 2'b01) begin
      errors++;
      $display("FAIL mid_idle got %b exp 01", req_ready);
    end
    req_valid      = '0;
    dram_rsp_valid = 1'b1;
    dram_rsp_id    = 9'h000;
    @(negedge clk);
    dram_rsp_valid = 1'b0;
    checks++;
    if (err !== 1'b1) begin
      errors++;
      $display("FAIL mid_count got err %b exp 1", err);
    end
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_alternate();
    test_burst();
    test_stall();
    test_outstanding();
    test_err_cancel();
    test_reset_mid_burst();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
